flux_fifo_bank: RTL and testbench

- Responder end of the dataflow actor FIFO protocol: one bank of FLUX independent queues behind a single tagged write port and a per-flux read port.
- An actor's output is `din`/`write`/`full`. Each `din` word carries a flux tag in its top bits; the block routes the word into the queue selected by that tag.
- The consuming actor pops a chosen queue through `read`/`empty`. It receives the popped word, tag included, on `dout`.

---
 rtl/flux_fifo_bank.sv | 129 ++++++++++++
 tb/tb_flux_fifo_bank.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/flux_fifo_bank.sv
// flux_fifo_bank: FLUX independent FIFOs behind one tagged write port.
// Words are steered by the tag in their top bits. They are popped through a
// per-queue read strobe, and the popped word appears on dout one cycle later.

// One queue: storage, wrapping pointers and an occupancy count.
module flux_queue #(
  parameter int WW    = 5,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [WW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [WW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_cnt;

  // Storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk)
    if (i_wr) r_mem[r_wr_ptr] <= i_wdata;

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_wr, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
endmodule

module flux_fifo_bank #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int FLUX       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH+$clog2(FLUX)-1:0]   din,
  input  logic                                 write,
  output logic [FLUX-1:0]                      full,
  output logic [DATA_WIDTH+$clog2(FLUX)-1:0]   dout,
  input  logic [FLUX-1:0]                      read,
  output logic [FLUX-1:0]                      empty
);
  localparam int TW   = $clog2(FLUX);
  localparam int TAGW = (TW > 0) ? TW : 1;
  localparam int WW   = DATA_WIDTH + TW;

  logic [TAGW-1:0]          w_tag;
  logic [FLUX-1:0]          w_rd_sel;
  logic [FLUX-1:0]          w_pop;
  logic [FLUX-1:0]          w_wr;
  logic [FLUX-1:0][WW-1:0]  w_rdata;
  logic [WW-1:0]            w_rd_word;

  // A single queue has no tag bits; everything lands in queue 0.
  generate
    if (TW > 0) begin : g_tag
      assign w_tag = din[WW-1:DATA_WIDTH];
    end else begin : g_notag
      assign w_tag = '0;
    end
  endgenerate

  // Lowest set read bit wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    w_rd_sel = '0;
    for (int i = FLUX-1; i >= 0; i--)
      if (read[i]) begin
        w_rd_sel    = '0;
        w_rd_sel[i] = 1'b1;
      end
  end

  // Per-queue pop/write qualification; a full queue still accepts when it pops
  // the same cycle, and out-of-range tags match no queue and are dropped.
  genvar g;
  generate
    for (g = 0; g < FLUX; g++) begin : g_q
      assign w_pop[g] = w_rd_sel[g] & ~empty[g];
      assign w_wr[g]  = write & (w_tag == TAGW'(g)) & (~full[g] | w_pop[g]);

      flux_queue #(.WW(WW), .DEPTH(DEPTH)) u_q (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr[g]),
        .i_wdata (din),
        .i_pop   (w_pop[g]),
        .o_rdata (w_rdata[g]),
        .o_full  (full[g]),
        .o_empty (empty[g])
      );
    end
  endgenerate

  // w_pop is at most one-hot, so an OR-style select picks the popped head.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < FLUX; i++)
      if (w_pop[i]) w_rd_word = w_rdata[i];
  end

  // dout captures the head on a successful pop and otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout <= '0;
    else if (|w_pop) dout <= w_rd_word;
  end
endmodule

// File: tb/tb_flux_fifo_bank.sv
// Directed bench for flux_fifo_bank (FLUX=2, DATA_WIDTH=4, DEPTH=4).
// A per-queue reference model predicts pops; predicted words go to a
// scoreboard queue and are compared against dout after the next edge.
module tb_flux_fifo_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] din = '0;
  logic       write = 1'b0;
  logic [1:0] full;
  logic [4:0] dout;
  logic [1:0] read = '0;
  logic [1:0] empty;

  int total = 0;
  int bad   = 0;

  logic [4:0] mq0[$];
  logic [4:0] mq1[$];
  logic [4:0] exp_q[$];
  logic [4:0] md = '0;

  flux_fifo_bank #(.DATA_WIDTH(4), .DEPTH(4), .FLUX(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .write (write),
    .full  (full),
    .dout  (dout),
    .read  (read),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Async reset asserted between edges; outputs must react without a clock.
  task automatic do_reset();
    @(negedge clk);
    write = 1'b0; read = '0; rst = 1'b1;
    #1;
    mq0.delete(); mq1.delete(); exp_q.delete(); md = '0;
    chk("rst_full",  full,  2'b00);
    chk("rst_empty", empty, 2'b11);
    chk("rst_dout",  dout,  5'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus: model predicts, then DUT outputs are checked after the edge.
  task automatic step(input logic w, input logic [4:0] d, input logic [1:0] r);
    logic [4:0] pv;
    @(negedge clk);
    write = w; din = d; read = r;
    if (r[0]) begin
      if (mq0.size() > 0) begin pv = mq0.pop_front(); exp_q.push_back(pv); end
    end else if (r[1]) begin
      if (mq1.size() > 0) begin pv = mq1.pop_front(); exp_q.push_back(pv); end
    end
    if (w) begin
      if (d[4] == 1'b0) begin
        if (mq0.size() < 4) mq0.push_back(d);
      end else begin
        if (mq1.size() < 4) mq1.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) md = exp_q.pop_front();
    chk("dout",  dout,  md);
    chk("full",  full,  {mq1.size() == 4, mq0.size() == 4});
    chk("empty", empty, {mq1.size() == 0, mq0.size() == 0});
  endtask

  initial begin
    // 1. Reset, then reset discards a queued word.
    do_reset();
    step(1, 5'h03, 2'b00);
    chk("t1_q0_not_empty", empty[0], 1'b0);
    do_reset();
    chk("t1_q0_empty_again", empty[0], 1'b1);

    // 2. Routing and order.
    step(1, 5'h01, 2'b00);
    step(1, 5'h12, 2'b00);
    step(1, 5'h03, 2'b00);
    step(0, 5'h00, 2'b01);
    chk("t2_first", dout, 5'h01);
    step(0, 5'h00, 2'b01);
    chk("t2_second", dout, 5'h03);
    step(0, 5'h00, 2'b10);
    chk("t2_third", dout, 5'h12);
    chk("t2_empty", empty, 2'b11);

    // 3. Fill queue 0 and overflow by one.
    for (int i = 0; i < 5; i++) begin
      step(1, 5'(i), 2'b00);
      if (i == 3) chk("t3_full_at4", full[0], 1'b1);
    end
    for (int i = 0; i < 4; i++) step(0, 5'h00, 2'b01);
    chk("t3_last", dout, 5'h03);
    chk("t3_empty", empty[0], 1'b1);

    // 4. Write and pop together on a full queue.
    for (int i = 0; i < 4; i++) step(1, 5'(8'h0A + i), 2'b00);
    step(1, 5'h0E, 2'b01);
    chk("t4_pop", dout, 5'h0A);
    chk("t4_still_full", full[0], 1'b1);
    for (int i = 0; i < 4; i++) step(0, 5'h00, 2'b01);
    chk("t4_last", dout, 5'h0E);

    // 5. Empty read holds dout; multi-bit read serves the lowest queue only.
    step(1, 5'h12, 2'b00);
    step(0, 5'h00, 2'b10);
    step(0, 5'h00, 2'b01);
    chk("t5_hold", dout, 5'h12);
    step(1, 5'h05, 2'b00);
    step(1, 5'h16, 2'b00);
    step(0, 5'h00, 2'b11);
    chk("t5_lowest", dout, 5'h05);
    chk("t5_q1_kept", empty[1], 1'b0);
    step(0, 5'h00, 2'b10);
    chk("t5_q1_word", dout, 5'h16);

    // 6. Streaming write+read on queue 1; pointers wrap repeatedly.
    for (int i = 0; i < 12; i++) step(1, {1'b1, 4'(i)}, 2'b10);
    step(0, 5'h00, 2'b10);
    chk("t6_last", dout, 5'h1B);
    chk("t6_empty", empty, 2'b11);

    write = 1'b0; read = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
